// File: rtl/hash_msg_feeder_if.sv
// Bundles the source byte stream, the hash-core side and the status strobes of hash_msg_feeder.
// master is the feeder itself; slave is the environment driving it.
interface hash_msg_feeder_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [7:0]  m;
  logic        m_valid;
  logic        hash_ready;
  logic [63:0] hash_out;
  logic [63:0] digest;
  logic        digest_valid;
  logic        err_illegal;
  logic        busy;

  modport master (
    input  s_data, s_valid, s_last, hash_ready, hash_out,
    output s_ready, m, m_valid, digest, digest_valid, err_illegal, busy
  );

  modport slave (
    output s_data, s_valid, s_last, hash_ready, hash_out,
    input  s_ready, m, m_valid, digest, digest_valid, err_illegal, busy
  );
endinterface

// File: rtl/hash_msg_feeder.sv
// Buffers message bytes and feeds them to an iterative hash core framed by 8'hFF start and
// 8'h00 finish bytes, pacing strobes PACE cycles apart, then captures the resulting digest.
module hash_msg_feeder #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PACE       = 34
) (
  input  logic              clk,
  input  logic              reset,
  hash_msg_feeder_if.master bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = (PACE > 2) ? $clog2(PACE) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(PACE - 1);

  typedef enum logic [2:0] {
    IDLE, SEND_START, PACE_WAIT, SEND_BYTE, SEND_FINISH, WAIT_DIGEST
  } state_t;

  // Entry layout: {skip, last, byte}
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          full, empty, push, pop, pop_skip, pop_byte, new_skip;
  logic [9:0]    head;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_seen;

  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty    = (wptr == rptr);
  assign push     = bus.s_valid && !full;
  assign new_skip = (bus.s_data == 8'hFF) || (bus.s_data == 8'h00);
  assign head     = mem[rptr[AW-1:0]];
  assign pop      = pop_skip | pop_byte;

  assign bus.s_ready = !full;
  assign bus.busy    = (state != IDLE);

  // Skip entries are drained as soon as they reach the head so they never stretch the pacing;
  // nothing is popped once the final beat has been seen, so the next message stays queued.
  always_comb begin
    pop_skip = 1'b0;
    pop_byte = 1'b0;
    if (state == PACE_WAIT && !empty && !last_seen) begin
      if (head[9])         pop_skip = 1'b1;
      else if (cnt == '0)  pop_byte = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {new_skip, bus.s_last, bus.s_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // The counter is loaded on the edge that raises m_valid, so it reads PACE-1 during the
  // strobe cycle and reaches zero exactly PACE-1 cycles later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      last_seen        <= 1'b0;
      bus.m            <= 8'h00;
      bus.m_valid      <= 1'b0;
      bus.digest       <= '0;
      bus.digest_valid <= 1'b0;
      bus.err_illegal  <= 1'b0;
    end else begin
      bus.m_valid      <= 1'b0;
      bus.digest_valid <= 1'b0;
      bus.err_illegal  <= push && new_skip;
      if (cnt != '0) cnt <= cnt - 1'b1;
      unique case (state)
        IDLE: begin
          if (!empty) begin
            bus.m       <= 8'hFF;
            bus.m_valid <= 1'b1;
            cnt         <= RELOAD;
            state       <= SEND_START;
          end
        end
        SEND_START, SEND_BYTE: state <= PACE_WAIT;
        PACE_WAIT: begin
          if (cnt == '0 && last_seen) begin
            bus.m       <= 8'h00;
            bus.m_valid <= 1'b1;
            last_seen   <= 1'b0;
            state       <= SEND_FINISH;
          end else if (pop_byte) begin
            bus.m       <= head[7:0];
            bus.m_valid <= 1'b1;
            cnt         <= RELOAD;
            last_seen   <= head[8];
            state       <= SEND_BYTE;
          end else if (pop_skip && head[8]) begin
            last_seen <= 1'b1;
          end
        end
        SEND_FINISH: state <= WAIT_DIGEST;
        WAIT_DIGEST: begin
          if (bus.hash_ready) begin
            bus.digest       <= bus.hash_out;
            bus.digest_valid <= 1'b1;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
